// File: rtl/kinase_ctrl_pkg.sv
// Shared constants, types and pump phase tables for the kinase-chip valve sequencer.
// Pad widths match the chip's control and pump valve groups.
package kinase_ctrl_pkg;

  localparam int CTRL_A_W     = 13;
  localparam int CTRL_S_W     = 4;
  localparam int PUMP_A_W     = 3;
  localparam int PUMP_B_W     = 2;
  localparam int STEP_DWELL_W = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_STEP  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    STEP  = ST_STEP,
    FLUSH = ST_FLUSH
  } kv_state_e;

  // Peristaltic sequences; entry 0 is the phase shown right after a run starts.
  localparam logic [PUMP_A_W-1:0] PUMP_A_SEQ [0:5] = '{
    3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101
  };
  localparam logic [PUMP_B_W-1:0] PUMP_B_SEQ [0:3] = '{
    2'b10, 2'b11, 2'b01, 2'b00
  };

  typedef struct packed {
    logic [CTRL_A_W-1:0]     ctrl_a;
    logic [CTRL_S_W-1:0]     ctrl_s;
    logic [1:0]              pump_en;
    logic [STEP_DWELL_W-1:0] dwell;
  } step_entry_t;

  function automatic logic [2:0] pump_last_phase(input int valves);
    return (valves == PUMP_A_W) ? 3'd5 : 3'd3;
  endfunction

endpackage

// File: rtl/kinase_valve_sequencer_pump_gen.sv
// Phase generator for one peristaltic pump group; the valve pattern is registered
// and forced to 0 whenever the pump is not enabled for the coming cycle.
module peristaltic_pump_gen
  import kinase_ctrl_pkg::*;
#(
  parameter int VALVES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic              tick,
  output logic [VALVES-1:0] valves
);

  localparam logic [2:0] LAST_PHASE = pump_last_phase(VALVES);

  logic [2:0]        phase_reg;
  logic [2:0]        phase_next;
  logic [VALVES-1:0] pattern_next;
  logic [VALVES-1:0] valves_reg;

  always_comb begin
    phase_next = phase_reg;
    if (enable && tick) begin
      phase_next = (phase_reg == LAST_PHASE) ? 3'd0 : phase_reg + 3'd1;
    end
  end

  if (VALVES == PUMP_A_W) begin : g_pump_a
    assign pattern_next = PUMP_A_SEQ[phase_next];
  end else begin : g_pump_b
    assign pattern_next = PUMP_B_SEQ[phase_next[1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      phase_reg  <= 3'd0;
      valves_reg <= '0;
    end else begin
      phase_reg  <= phase_next;
      valves_reg <= enable ? pattern_next : '0;
    end
  end

  assign valves = valves_reg;

endmodule

// File: rtl/kinase_valve_sequencer.sv
// Plays a preloaded valve-step table onto the chip pads, drives two peristaltic pumps
// and finishes every run (normal or aborted) with a timed flush of all control lines.
module kinase_valve_sequencer
  import kinase_ctrl_pkg::*;
#(
  parameter int STEPS   = 16,
  parameter int DWELL_W = STEP_DWELL_W,
  parameter int DIV_W   = 12,
  parameter int FLUSH_W = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [$clog2(STEPS)-1:0] cfg_addr,
  input  logic [CTRL_A_W-1:0]      cfg_ctrl_a,
  input  logic [CTRL_S_W-1:0]      cfg_ctrl_s,
  input  logic [1:0]               cfg_pump_en,
  input  logic [DWELL_W-1:0]       cfg_dwell,
  input  logic [$clog2(STEPS):0]   num_steps,
  input  logic [DIV_W-1:0]         pump_div,
  input  logic [FLUSH_W-1:0]       flush_cycles,
  input  logic                     start,
  input  logic                     abort,
  output logic [CTRL_A_W-1:0]      pad_ctrl_a,
  output logic [CTRL_S_W-1:0]      pad_ctrl_s,
  output logic [PUMP_A_W-1:0]      pad_pump_a,
  output logic [PUMP_B_W-1:0]      pad_pump_b,
  output logic [CTRL_A_W-1:0]      pad_flush_ctrl_a,
  output logic [CTRL_S_W-1:0]      pad_flush_ctrl_s,
  output logic [PUMP_A_W-1:0]      pad_flush_pump_a,
  output logic [PUMP_B_W-1:0]      pad_flush_pump_b,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(STEPS)-1:0] step_idx
);

  localparam int IW = $clog2(STEPS);

  // Step table: written only while idle, read through a registered port.
  step_entry_t table_mem [STEPS];
  step_entry_t rd_data_reg;
  step_entry_t wr_entry;
  logic [IW-1:0] rd_addr;

  logic [1:0]          state_reg, state_next;
  logic [IW-1:0]       step_idx_reg, step_idx_next;
  logic                load_pending_reg;
  logic [IW:0]         num_steps_reg;
  logic [DIV_W-1:0]    pump_div_reg;
  logic [FLUSH_W-1:0]  flush_cycles_reg;
  logic [DWELL_W-1:0]  dwell_cnt_reg;
  logic [FLUSH_W-1:0]  flush_cnt_reg;
  logic [DIV_W-1:0]    div_cnt_reg;
  logic [1:0]          pump_en_reg, pump_en_next;
  logic [CTRL_A_W-1:0] pad_ctrl_a_reg, pad_flush_ctrl_a_reg;
  logic [CTRL_S_W-1:0] pad_ctrl_s_reg, pad_flush_ctrl_s_reg;
  logic [PUMP_A_W-1:0] pad_flush_pump_a_reg;
  logic [PUMP_B_W-1:0] pad_flush_pump_b_reg;
  logic                done_reg;

  logic run_start, in_display, step_done, last_step;
  logic load_now, enter_flush, pump_tick;

  assign wr_entry = '{ctrl_a:  cfg_ctrl_a,
                      ctrl_s:  cfg_ctrl_s,
                      pump_en: cfg_pump_en,
                      dwell:   STEP_DWELL_W'(cfg_dwell)};

  always_ff @(posedge clk) begin
    if (cfg_we && (state_reg == ST_IDLE)) begin
      table_mem[cfg_addr] <= wr_entry;
    end
    rd_data_reg <= table_mem[rd_addr];
  end

  always_comb begin
    run_start     = (state_reg == ST_IDLE) && start;
    in_display    = (state_reg == ST_STEP) && !load_pending_reg;
    step_done     = in_display && (dwell_cnt_reg == '0);
    last_step     = ({1'b0, step_idx_reg} == (num_steps_reg - (IW+1)'(1)));
    pump_tick     = in_display && (div_cnt_reg == pump_div_reg);
    state_next    = state_reg;
    step_idx_next = step_idx_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          step_idx_next = '0;
          state_next    = (num_steps == '0) ? ST_FLUSH : ST_STEP;
        end
      end
      ST_STEP: begin
        if (abort) begin
          state_next = ST_FLUSH;
        end else if (step_done) begin
          if (last_step) begin
            state_next = ST_FLUSH;
          end else begin
            step_idx_next = step_idx_reg + IW'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_reg == '0) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // rd_data_reg always holds the entry that the next step transition will consume.
    load_now    = (state_reg == ST_STEP) && !abort &&
                  (load_pending_reg || (step_done && !last_step));
    rd_addr     = run_start ? '0 : step_idx_next + IW'(1);
    enter_flush = (state_next == ST_FLUSH) && (state_reg != ST_FLUSH);

    if (load_now) begin
      pump_en_next = rd_data_reg.pump_en;
    end else if (state_next == ST_STEP) begin
      pump_en_next = pump_en_reg;
    end else begin
      pump_en_next = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg            <= ST_IDLE;
      step_idx_reg         <= '0;
      load_pending_reg     <= 1'b0;
      num_steps_reg        <= '0;
      pump_div_reg         <= '0;
      flush_cycles_reg     <= '0;
      dwell_cnt_reg        <= '0;
      flush_cnt_reg        <= '0;
      div_cnt_reg          <= '0;
      pump_en_reg          <= 2'b00;
      pad_ctrl_a_reg       <= '0;
      pad_ctrl_s_reg       <= '0;
      pad_flush_ctrl_a_reg <= '0;
      pad_flush_ctrl_s_reg <= '0;
      pad_flush_pump_a_reg <= '0;
      pad_flush_pump_b_reg <= '0;
      done_reg             <= 1'b0;
    end else begin
      state_reg    <= state_next;
      step_idx_reg <= step_idx_next;
      done_reg     <= 1'b0;

      if (run_start) begin
        num_steps_reg    <= num_steps;
        pump_div_reg     <= pump_div;
        flush_cycles_reg <= flush_cycles;
        load_pending_reg <= 1'b1;
        div_cnt_reg      <= '0;
        pump_en_reg      <= 2'b00;
      end

      // The pump divider free-runs over every displayed cycle, enabled or not.
      if (in_display) begin
        div_cnt_reg <= pump_tick ? '0 : div_cnt_reg + DIV_W'(1);
      end

      if (load_now) begin
        pad_ctrl_a_reg   <= rd_data_reg.ctrl_a;
        pad_ctrl_s_reg   <= rd_data_reg.ctrl_s;
        pump_en_reg      <= rd_data_reg.pump_en;
        dwell_cnt_reg    <= DWELL_W'(rd_data_reg.dwell);
        load_pending_reg <= 1'b0;
      end else if (in_display && (dwell_cnt_reg != '0)) begin
        dwell_cnt_reg <= dwell_cnt_reg - DWELL_W'(1);
      end

      if (enter_flush) begin
        pad_ctrl_a_reg       <= '0;
        pad_ctrl_s_reg       <= '0;
        pump_en_reg          <= 2'b00;
        pad_flush_ctrl_a_reg <= '1;
        pad_flush_ctrl_s_reg <= '1;
        pad_flush_pump_a_reg <= '1;
        pad_flush_pump_b_reg <= '1;
        flush_cnt_reg        <= run_start ? flush_cycles : flush_cycles_reg;
        load_pending_reg     <= 1'b0;
      end else if ((state_reg == ST_FLUSH) && (flush_cnt_reg == '0)) begin
        pad_flush_ctrl_a_reg <= '0;
        pad_flush_ctrl_s_reg <= '0;
        pad_flush_pump_a_reg <= '0;
        pad_flush_pump_b_reg <= '0;
        done_reg             <= 1'b1;
      end else if (state_reg == ST_FLUSH) begin
        flush_cnt_reg <= flush_cnt_reg - FLUSH_W'(1);
      end
    end
  end

  peristaltic_pump_gen #(.VALVES(PUMP_A_W)) u_pump_a (
    .clk    (clk),
    .rst    (rst),
    .clear  (run_start),
    .enable (pump_en_next[0]),
    .tick   (pump_tick),
    .valves (pad_pump_a)
  );

  peristaltic_pump_gen #(.VALVES(PUMP_B_W)) u_pump_b (
    .clk    (clk),
    .rst    (rst),
    .clear  (run_start),
    .enable (pump_en_next[1]),
    .tick   (pump_tick),
    .valves (pad_pump_b)
  );

  assign pad_ctrl_a       = pad_ctrl_a_reg;
  assign pad_ctrl_s       = pad_ctrl_s_reg;
  assign pad_flush_ctrl_a = pad_flush_ctrl_a_reg;
  assign pad_flush_ctrl_s = pad_flush_ctrl_s_reg;
  assign pad_flush_pump_a = pad_flush_pump_a_reg;
  assign pad_flush_pump_b = pad_flush_pump_b_reg;
  assign busy             = (state_reg != ST_IDLE);
  assign done             = done_reg;
  assign step_idx         = step_idx_reg;

endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// Scoreboard bench: each run's per-cycle pad trace is modelled up front and
// compared cycle by cycle against the sequencer outputs.
module tb_kinase_valve_sequencer;

  localparam int STEPS   = 16;
  localparam int DWELL_W = 16;
  localparam int DIV_W   = 12;
  localparam int FLUSH_W = 12;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_we = 1'b0;
  logic [3:0]         cfg_addr = '0;
  logic [12:0]        cfg_ctrl_a = '0;
  logic [3:0]         cfg_ctrl_s = '0;
  logic [1:0]         cfg_pump_en = '0;
  logic [DWELL_W-1:0] cfg_dwell = '0;
  logic [4:0]         num_steps = '0;
  logic [DIV_W-1:0]   pump_div = '0;
  logic [FLUSH_W-1:0] flush_cycles = '0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [12:0]        pad_ctrl_a, pad_flush_ctrl_a;
  logic [3:0]         pad_ctrl_s, pad_flush_ctrl_s;
  logic [2:0]         pad_pump_a, pad_flush_pump_a;
  logic [1:0]         pad_pump_b, pad_flush_pump_b;
  logic               busy, done;
  logic [3:0]         step_idx;

  typedef struct packed {
    logic [12:0] a;
    logic [3:0]  s;
    logic [2:0]  pa;
    logic [1:0]  pb;
    logic [12:0] fa;
    logic [3:0]  fs;
    logic [2:0]  fpa;
    logic [1:0]  fpb;
    logic [3:0]  idx;
    logic        busy;
    logic        done;
  } obs_t;

  obs_t exp_q[$];
  int checks = 0;
  int errors = 0;

  logic [12:0] tb_a  [STEPS];
  logic [3:0]  tb_s  [STEPS];
  logic [1:0]  tb_pe [STEPS];
  int          tb_dw [STEPS];
  logic [2:0]  seq_a [6];
  logic [1:0]  seq_b [4];

  kinase_valve_sequencer #(
    .STEPS(STEPS), .DWELL_W(DWELL_W), .DIV_W(DIV_W), .FLUSH_W(FLUSH_W)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_ctrl_a(cfg_ctrl_a), .cfg_ctrl_s(cfg_ctrl_s), .cfg_pump_en(cfg_pump_en),
    .cfg_dwell(cfg_dwell), .num_steps(num_steps), .pump_div(pump_div),
    .flush_cycles(flush_cycles), .start(start), .abort(abort),
    .pad_ctrl_a(pad_ctrl_a), .pad_ctrl_s(pad_ctrl_s), .pad_pump_a(pad_pump_a),
    .pad_pump_b(pad_pump_b), .pad_flush_ctrl_a(pad_flush_ctrl_a),
    .pad_flush_ctrl_s(pad_flush_ctrl_s), .pad_flush_pump_a(pad_flush_pump_a),
    .pad_flush_pump_b(pad_flush_pump_b), .busy(busy), .done(done), .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample_obs();
    obs_t o;
    o = {pad_ctrl_a, pad_ctrl_s, pad_pump_a, pad_pump_b, pad_flush_ctrl_a,
         pad_flush_ctrl_s, pad_flush_pump_a, pad_flush_pump_b, step_idx, busy, done};
    return o;
  endfunction

  task automatic write_entry(input int addr, input logic [12:0] a, input logic [3:0] s,
                             input logic [1:0] pe, input int dw);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = addr[3:0]; cfg_ctrl_a = a; cfg_ctrl_s = s;
    cfg_pump_en = pe; cfg_dwell = DWELL_W'(dw);
    @(negedge clk);
    cfg_we = 1'b0;
    tb_a[addr] = a; tb_s[addr] = s; tb_pe[addr] = pe; tb_dw[addr] = dw;
  endtask

  // Expected trace: one pending cycle, dwell+1 cycles per step, flush_cycles+1 flush
  // cycles, one done cycle, one idle cycle. Pumps advance every div+1 displayed cycles.
  task automatic build_expect(input int n, input int fl, input int div, input int abort_at);
    obs_t e;
    int cyc, k, ph_a, ph_b;
    logic [3:0] idx;
    bit aborted;
    cyc = 0; k = 0; ph_a = 0; ph_b = 0; idx = '0; aborted = 0;
    if (n > 0) begin
      e = '0; e.busy = 1'b1;
      exp_q.push_back(e);
      if (abort_at == 0) aborted = 1;
      cyc = 1;
      for (int s = 0; s < n && !aborted; s++) begin
        for (int d = 0; d <= tb_dw[s] && !aborted; d++) begin
          idx = s[3:0];
          if (k > 0 && ((k - 1) % (div + 1)) == div) begin
            if (tb_pe[s][0]) ph_a = (ph_a + 1) % 6;
            if (tb_pe[s][1]) ph_b = (ph_b + 1) % 4;
          end
          e = '0;
          e.a = tb_a[s]; e.s = tb_s[s];
          e.pa = tb_pe[s][0] ? seq_a[ph_a] : 3'b000;
          e.pb = tb_pe[s][1] ? seq_b[ph_b] : 2'b00;
          e.idx = idx; e.busy = 1'b1;
          exp_q.push_back(e);
          if (cyc == abort_at) aborted = 1;
          cyc++; k++;
        end
      end
    end
    for (int f = 0; f <= fl; f++) begin
      e = '0; e.fa = '1; e.fs = '1; e.fpa = '1; e.fpb = '1; e.idx = idx; e.busy = 1'b1;
      exp_q.push_back(e);
    end
    e = '0; e.idx = idx; e.done = 1'b1;
    exp_q.push_back(e);
    e = '0; e.idx = idx;
    exp_q.push_back(e);
  endtask

  task automatic run_trace(input int n, input int fl, input int div, input int abort_at,
                           input bit poke_start, input bit poke_cfg);
    obs_t e, o;
    int cyc, errs_before;
    errs_before = errors;
    build_expect(n, fl, div, abort_at);
    @(negedge clk);
    num_steps = 5'(n); flush_cycles = FLUSH_W'(fl); pump_div = DIV_W'(div);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = sample_obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL trace n=%0d cyc=%0d: got %h expected %h", n, cyc, o, e);
      end
      abort = (cyc == abort_at);
      start = poke_start && (cyc == 2 || cyc == abort_at + 2);
      cfg_we = poke_cfg && (cyc == 1);
      if (poke_cfg && cyc == 1) begin
        cfg_addr = 4'd0; cfg_ctrl_a = 13'h0AAA; cfg_ctrl_s = 4'h3;
        cfg_pump_en = 2'b11; cfg_dwell = DWELL_W'(7);
      end
      @(negedge clk);
      cyc++;
    end
    abort = 1'b0; start = 1'b0; cfg_we = 1'b0;
    $display("run n=%0d flush=%0d div=%0d abort_at=%0d cycles=%0d new_errors=%0d",
             n, fl, div, abort_at, cyc, errors - errs_before);
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      o = sample_obs();
      checks++;
      if (o !== obs_t'(0)) begin
        errors++;
        $display("FAIL reset_state: got %h expected %h", o, obs_t'(0));
      end
    end
    $display("reset state checked");
  endtask

  task automatic test_three_step();
    write_entry(0, 13'h1001, 4'h0, 2'b00, 4);
    write_entry(1, 13'h0000, 4'hA, 2'b00, 0);
    write_entry(2, 13'h1FFF, 4'h0, 2'b00, 2);
    run_trace(3, 5, 0, -1, 0, 0);
  endtask

  task automatic test_pump_a();
    write_entry(0, 13'h0000, 4'h0, 2'b01, 19);
    run_trace(1, 1, 2, -1, 0, 0);
  endtask

  task automatic test_abort();
    write_entry(0, 13'h0011, 4'h1, 2'b00, 2);
    write_entry(1, 13'h0022, 4'h2, 2'b00, 5);
    write_entry(2, 13'h0044, 4'h4, 2'b00, 3);
    write_entry(3, 13'h0088, 4'h8, 2'b00, 1);
    run_trace(4, 3, 0, 6, 1, 0);
  endtask

  task automatic test_zero_steps();
    run_trace(0, 3, 0, -1, 1, 0);
  endtask

  task automatic test_cfg_we_busy();
    write_entry(0, 13'h0F0F, 4'h5, 2'b00, 1);
    run_trace(1, 0, 0, -1, 0, 1);
    run_trace(1, 0, 0, -1, 0, 0);
  endtask

  task automatic test_back_to_back();
    write_entry(0, 13'h0123, 4'h1, 2'b11, 3);
    write_entry(1, 13'h0456, 4'h2, 2'b01, 0);
    write_entry(2, 13'h0789, 4'h4, 2'b10, 4);
    write_entry(3, 13'h0ABC, 4'h8, 2'b11, 2);
    run_trace(4, 2, 1, -1, 0, 0);
    run_trace(4, 0, 0, -1, 0, 0);
  endtask

  task automatic test_reset_midrun();
    obs_t o;
    @(negedge clk);
    num_steps = 5'd3; flush_cycles = FLUSH_W'(2); pump_div = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      o = sample_obs();
      checks++;
      if (o !== obs_t'(0)) begin
        errors++;
        $display("FAIL reset_midrun cyc=%0d: got %h expected %h", i, o, obs_t'(0));
      end
    end
    $display("mid-run reset checked");
  endtask

  initial begin
    seq_a = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
    seq_b = '{2'b10, 2'b11, 2'b01, 2'b00};
    test_reset();
    test_three_step();
    test_pump_a();
    test_abort();
    test_zero_steps();
    test_cfg_we_busy();
    test_back_to_back();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/kinase_valve_sequencer.md
Name: kinase_valve_sequencer

Overview:
Off-chip pneumatic controller that drives the control and flush pads of the kinase-activity chip.
- Plays a preloaded table of valve steps onto the 13 `ctrl_a` valves and 4 `ctrl_s` valves.
- Generates peristaltic phase patterns on pump groups A (3 valves) and B (2 valves).
- Ends every run, or any abort, with a timed flush of all control lines.
- Sits between the host/test-bench register interface and the chip's control and flush pad inputs.

Parameters:
- STEPS, 16, depth of the step table (power of two).
- DWELL_W, 16, width of per-step dwell count.
- DIV_W, 12, width of pump phase-rate divider.
- FLUSH_W, 12, width of flush duration count.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- cfg_we  input  1  write step-table entry at cfg_addr; ignored while busy.
- cfg_addr  input  $clog2(STEPS)  step index.
- cfg_ctrl_a  input  13  ctrl_a valve pattern for the step.
- cfg_ctrl_s  input  4  ctrl_s valve pattern for the step.
- cfg_pump_en  input  2  bit0 enables pump A, bit1 enables pump B, during the step.
- cfg_dwell  input  DWELL_W  step lasts cfg_dwell+1 cycles.
- num_steps  input  $clog2(STEPS)+1  steps to run, 0..STEPS; sampled at start.
- pump_div  input  DIV_W  pump phase advances every pump_div+1 cycles; sampled at start.
- flush_cycles  input  FLUSH_W  flush lasts flush_cycles+1 cycles; sampled at start.
- start  input  1  single-cycle run request.
- abort  input  1  single-cycle abort request.
- pad_ctrl_a  output  13  to chip pad_ctrl_a.
- pad_ctrl_s  output  4  to chip pad_ctrl_s.
- pad_pump_a  output  3  to chip pad_pump_a.
- pad_pump_b  output  2  to chip pad_pump_b.
- pad_flush_ctrl_a  output  13  flush line for ctrl_a.
- pad_flush_ctrl_s  output  4  flush line for ctrl_s.
- pad_flush_pump_a  output  3  flush line for pump_a.
- pad_flush_pump_b  output  2  flush line for pump_b.
- busy  output  1  high outside IDLE.
- done  output  1  one-cycle pulse when a run, or an aborted run, completes.
- step_idx  output  $clog2(STEPS)  index of the current step.

Behaviour:
- Reset: all outputs 0; state IDLE; pump phases 0.
- Pad outputs are registered. A value of 1 means valve pressurised (closed).
- States:
  - IDLE: start=1 samples parameters and goes to STEP with step_idx=0; if num_steps=0, goes directly to FLUSH.
  - STEP: the pads show table[step_idx] from the cycle after entry, for dwell+1 cycles. On the last cycle, step_idx increments, or the block enters FLUSH when step_idx=num_steps-1. Table read latency is absorbed by registering the entry when the step is entered.
  - FLUSH: all pad_ctrl_* and pad_pump_* are 0; all pad_flush_* are all-ones for flush_cycles+1 cycles. Then done=1 for one cycle and the block returns to IDLE.
- abort in STEP enters FLUSH next cycle. abort in FLUSH or IDLE is ignored.
- start is ignored when busy. When start and abort arrive in the same cycle in IDLE, start wins.
- Pump A sequence: 100 → 110 → 010 → 011 → 001 → 101 → wrap.
- Pump B sequence: 10 → 11 → 01 → 00 → wrap.
- Pump phase timing:
  - A pump advances one phase per pump_div+1 cycles while it is enabled in the current step.
  - When disabled, its output is 0 and its phase holds; the divider counter keeps running.
  - Pump phases reset to 0 at start.
- Table writes during IDLE take effect for the next run. Contents survive rst; there is no reset of the table memory.
- The dwell counter is exact: a step with cfg_dwell=0 lasts one cycle.

Decomposition:
- Package `kinase_ctrl_pkg`:
  - Pad width constants: 13, 4, 3, 2.
  - State enum: IDLE, STEP, FLUSH.
  - Pump A phase table (6 entries) and pump B phase table (4 entries).
  - Step-entry struct packing ctrl_a, ctrl_s, pump_en and dwell.
- Sub-module `peristaltic_pump_gen`:
  - Parameterised by valve count (3 or 2).
  - Inputs: clk, rst, clear, enable, tick.
  - Output: valve pattern.
  - Instantiated twice, sharing one divider in the top level.

Test Plan:
- Reset: assert rst for 2 cycles mid-run (in STEP) → all pads 0, busy=0, step_idx=0 the next cycle; no done pulse.
- 3-step run:
  - Table: {ctrl_a=13'h1001, dwell=4}, {ctrl_s=4'hA, dwell=0}, {ctrl_a=13'h1FFF, dwell=2}; num_steps=3; flush_cycles=5.
  - Required: pad patterns held for exactly 5, 1 and 3 cycles, then 6 cycles of all-ones flush, then done for one cycle, then busy=0.
- Pump A:
  - Step with pump_en=01, pump_div=2, dwell=19.
  - Required: pad_pump_a steps 100,110,010,011,001,101,100 at 3-cycle intervals; pad_pump_b stays 00.
- Abort:
  - Pulse abort during step 1 of a 4-step run.
  - Required: FLUSH next cycle, pad_ctrl_* 0, then done; start pulses during busy are ignored.
- num_steps=0: start → flush for flush_cycles+1 cycles, then done; no step patterns appear.
- cfg_we while busy: entry is unchanged; a rerun shows the original pattern.
